bus_trace_capture: RTL and testbench

// Upstream feeder for the seven-segment bus display. Snoops the CPU address/data bus.

---
 rtl/bus_trace_capture.sv | 177 +++++++++++++++++
 tb/tb_bus_trace_capture.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/bus_trace_capture.sv
// Bus trace capture: snoops CPU strobes into a circular history buffer and feeds
// one registered address/data entry to the display, live or browsed while frozen.

module btc_debounce #(
    parameter int CYCLES = 1000000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_raw,
    output logic press
);
    localparam int CW = (CYCLES < 2) ? 1 : $clog2(CYCLES + 1);

    logic          sync1_q, sync1_d;
    logic          sync2_q, sync2_d;
    logic          level_q, level_d;
    logic [CW-1:0] cnt_q, cnt_d;

    // The level only moves after CYCLES consecutive disagreeing samples; a
    // rising move is reported as a single-cycle press.
    always_comb begin
        sync1_d = btn_raw;
        sync2_d = sync1_q;
        level_d = level_q;
        cnt_d   = '0;
        press   = 1'b0;
        if (sync2_q != level_q) begin
            if (cnt_q == CW'(CYCLES - 1)) begin
                level_d = sync2_q;
                press   = sync2_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            level_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            level_q <= level_d;
            cnt_q   <= cnt_d;
        end
    end
endmodule

module bus_trace_capture #(
    parameter int DEPTH           = 16,
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int AW              = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [15:0]   cpu_address,
    input  logic [7:0]    cpu_data,
    input  logic          cpu_we,
    input  logic          cpu_re,
    input  logic          btn_freeze,
    input  logic          btn_prev,
    input  logic          btn_next,
    output logic [15:0]   disp_address,
    output logic [7:0]    disp_data,
    output logic          disp_is_write,
    output logic          frozen,
    output logic          overrun,
    output logic [AW-1:0] trace_pos,
    output logic [AW:0]   trace_count
);
    typedef enum logic {LIVE, FROZEN} state_t;

    state_t        state_q, state_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic [AW-1:0] pos_q, pos_d;
    logic          overrun_q, overrun_d;
    logic [24:0]   disp_q, disp_d;

    logic [24:0]   trace_mem [DEPTH];
    logic          freeze_press, prev_press, next_press;
    logic          valid, wr_en;
    logic [24:0]   new_entry;
    logic [AW-1:0] rd_idx;

    btc_debounce #(.CYCLES(DEBOUNCE_CYCLES)) u_db_freeze (
        .clk(clk), .rst_n(rst_n), .btn_raw(btn_freeze), .press(freeze_press));
    btc_debounce #(.CYCLES(DEBOUNCE_CYCLES)) u_db_prev (
        .clk(clk), .rst_n(rst_n), .btn_raw(btn_prev), .press(prev_press));
    btc_debounce #(.CYCLES(DEBOUNCE_CYCLES)) u_db_next (
        .clk(clk), .rst_n(rst_n), .btn_raw(btn_next), .press(next_press));

    assign valid     = cpu_we | cpu_re;
    assign new_entry = {cpu_address, cpu_data, cpu_we};
    assign rd_idx    = wr_ptr_q - AW'(1) - pos_q;

    always_comb begin
        state_d   = state_q;
        wr_ptr_d  = wr_ptr_q;
        count_d   = count_q;
        pos_d     = pos_q;
        overrun_d = overrun_q;
        wr_en     = 1'b0;
        unique case (state_q)
            LIVE: begin
                pos_d = '0;
                if (valid) begin
                    wr_en    = 1'b1;
                    wr_ptr_d = wr_ptr_q + 1'b1;
                    if (count_q != (AW+1)'(DEPTH))
                        count_d = count_q + 1'b1;
                end
                if (freeze_press)
                    state_d = FROZEN;
            end
            FROZEN: begin
                if (valid)
                    overrun_d = 1'b1;
                // Freeze outranks stepping; simultaneous prev+next cancel out.
                if (freeze_press) begin
                    state_d   = LIVE;
                    pos_d     = '0;
                    overrun_d = 1'b0;
                end else if (prev_press && !next_press) begin
                    if (({1'b0, pos_q} + 1'b1) < count_q)
                        pos_d = pos_q + 1'b1;
                end else if (next_press && !prev_press) begin
                    if (pos_q != '0)
                        pos_d = pos_q - 1'b1;
                end
            end
            default: state_d = LIVE;
        endcase

        // A fresh write bypasses the buffer so it shows on the very next cycle.
        if (wr_en)
            disp_d = new_entry;
        else if (count_q == '0)
            disp_d = '0;
        else
            disp_d = trace_mem[rd_idx];
    end

    always_ff @(posedge clk) begin
        if (wr_en)
            trace_mem[wr_ptr_q] <= new_entry;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= LIVE;
            wr_ptr_q  <= '0;
            count_q   <= '0;
            pos_q     <= '0;
            overrun_q <= 1'b0;
            disp_q    <= '0;
        end else begin
            state_q   <= state_d;
            wr_ptr_q  <= wr_ptr_d;
            count_q   <= count_d;
            pos_q     <= pos_d;
            overrun_q <= overrun_d;
            disp_q    <= disp_d;
        end
    end

    assign disp_address  = disp_q[24:9];
    assign disp_data     = disp_q[8:1];
    assign disp_is_write = disp_q[0];
    assign frozen        = (state_q == FROZEN);
    assign overrun       = overrun_q;
    assign trace_pos     = pos_q;
    assign trace_count   = count_q;
endmodule

// File: tb/tb_bus_trace_capture.sv
// Scoreboard bench for bus_trace_capture: stimulus queues expected display state,
// a negedge monitor pops and compares it against the DUT.

module tb_bus_trace_capture;
    localparam int DEPTH = 16;
    localparam int DB    = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] cpu_address = '0;
    logic [7:0]  cpu_data = '0;
    logic        cpu_we = 1'b0;
    logic        cpu_re = 1'b0;
    logic        btn_freeze = 1'b0;
    logic        btn_prev = 1'b0;
    logic        btn_next = 1'b0;
    logic [15:0] disp_address;
    logic [7:0]  disp_data;
    logic        disp_is_write;
    logic        frozen;
    logic        overrun;
    logic [3:0]  trace_pos;
    logic [4:0]  trace_count;

    bus_trace_capture #(.DEPTH(DEPTH), .DEBOUNCE_CYCLES(DB)) dut (
        .clk(clk), .rst_n(rst_n),
        .cpu_address(cpu_address), .cpu_data(cpu_data),
        .cpu_we(cpu_we), .cpu_re(cpu_re),
        .btn_freeze(btn_freeze), .btn_prev(btn_prev), .btn_next(btn_next),
        .disp_address(disp_address), .disp_data(disp_data),
        .disp_is_write(disp_is_write), .frozen(frozen), .overrun(overrun),
        .trace_pos(trace_pos), .trace_count(trace_count));

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [15:0] a;
        logic [7:0]  d;
        logic        w;
        logic        fr;
        logic        ov;
        logic [3:0]  pos;
        logic [4:0]  cnt;
    } exp_t;

    exp_t expQ[$];
    int   checks = 0;
    int   errors = 0;
    int   freezeRises = 0;
    logic frozenPrev = 1'b0;

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    // Monitor: every expectation queued since the last falling edge is compared here.
    always @(negedge clk) begin
        exp_t e;
        while (expQ.size() > 0) begin
            e = expQ.pop_front();
            cmp({e.name, ".disp_address"}, 32'(disp_address), 32'(e.a));
            cmp({e.name, ".disp_data"}, 32'(disp_data), 32'(e.d));
            cmp({e.name, ".disp_is_write"}, 32'(disp_is_write), 32'(e.w));
            cmp({e.name, ".frozen"}, 32'(frozen), 32'(e.fr));
            cmp({e.name, ".overrun"}, 32'(overrun), 32'(e.ov));
            cmp({e.name, ".trace_pos"}, 32'(trace_pos), 32'(e.pos));
            cmp({e.name, ".trace_count"}, 32'(trace_count), 32'(e.cnt));
        end
    end

    always @(negedge clk) begin
        frozenPrev <= frozen;
        if (frozen && !frozenPrev)
            freezeRises <= freezeRises + 1;
    end

    task automatic pushExpect(input string name, input logic [15:0] a, input logic [7:0] d,
                              input logic w, input logic fr, input logic ov,
                              input logic [3:0] pos, input logic [4:0] cnt);
        exp_t e;
        e.name = name; e.a = a; e.d = d; e.w = w;
        e.fr = fr; e.ov = ov; e.pos = pos; e.cnt = cnt;
        expQ.push_back(e);
    endtask

    task automatic checkOutput(input string name, input logic [15:0] a, input logic [7:0] d,
                               input logic w, input logic fr, input logic ov,
                               input logic [3:0] pos, input logic [4:0] cnt);
        @(posedge clk);
        #1;
        pushExpect(name, a, d, w, fr, ov, pos, cnt);
    endtask

    task automatic applyStimulus(input logic [15:0] a, input logic [7:0] d,
                                 input logic we, input logic re);
        @(negedge clk);
        cpu_address = a;
        cpu_data    = d;
        cpu_we      = we;
        cpu_re      = re;
        @(negedge clk);
        cpu_we = 1'b0;
        cpu_re = 1'b0;
    endtask

    // which: 0 = freeze, 1 = prev, 2 = next
    task automatic pressButton(input int which);
        @(negedge clk);
        if (which == 0) btn_freeze = 1'b1;
        else if (which == 1) btn_prev = 1'b1;
        else btn_next = 1'b1;
        repeat (10) @(negedge clk);
        btn_freeze = 1'b0;
        btn_prev   = 1'b0;
        btn_next   = 1'b0;
        repeat (10) @(negedge clk);
    endtask

    initial begin
        int risesBefore;

        // Reset held while the bus keeps strobing
        for (int i = 0; i < 3; i++) begin
            applyStimulus(16'h1000 + 16'(i), 8'(i), 1'b1, 1'b0);
            applyStimulus(16'h2000 + 16'(i), 8'(i), 1'b0, 1'b1);
            checkOutput("reset_hold", 16'h0, 8'h0, 1'b0, 1'b0, 1'b0, 4'd0, 5'd0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        checkOutput("after_release", 16'h0, 8'h0, 1'b0, 1'b0, 1'b0, 4'd0, 5'd0);

        // Single write, then a combined we+re cycle
        applyStimulus(16'h1234, 8'hAB, 1'b1, 1'b0);
        checkOutput("write1", 16'h1234, 8'hAB, 1'b1, 1'b0, 1'b0, 4'd0, 5'd1);
        applyStimulus(16'h2222, 8'h11, 1'b1, 1'b1);
        checkOutput("we_and_re", 16'h2222, 8'h11, 1'b1, 1'b0, 1'b0, 4'd0, 5'd2);

        // Overfill with 20 reads, freeze, browse to the oldest and clamp
        for (int i = 0; i < 20; i++)
            applyStimulus(16'(i), 8'(i + 'h40), 1'b0, 1'b1);
        checkOutput("fill", 16'h0013, 8'h53, 1'b0, 1'b0, 1'b0, 4'd0, 5'd16);
        pressButton(1);
        checkOutput("prev_in_live", 16'h0013, 8'h53, 1'b0, 1'b0, 1'b0, 4'd0, 5'd16);
        pressButton(0);
        checkOutput("freeze", 16'h0013, 8'h53, 1'b0, 1'b1, 1'b0, 4'd0, 5'd16);
        pressButton(2);
        checkOutput("next_at_0", 16'h0013, 8'h53, 1'b0, 1'b1, 1'b0, 4'd0, 5'd16);
        for (int i = 0; i < 15; i++)
            pressButton(1);
        checkOutput("prev15", 16'h0004, 8'h44, 1'b0, 1'b1, 1'b0, 4'd15, 5'd16);
        pressButton(1);
        checkOutput("prev_clamp", 16'h0004, 8'h44, 1'b0, 1'b1, 1'b0, 4'd15, 5'd16);
        pressButton(2);
        checkOutput("next", 16'h0005, 8'h45, 1'b0, 1'b1, 1'b0, 4'd14, 5'd16);

        // Strobes while frozen are dropped and flagged
        for (int i = 0; i < 3; i++)
            applyStimulus(16'h9000 + 16'(i), 8'(i), 1'b1, 1'b0);
        checkOutput("overrun", 16'h0005, 8'h45, 1'b0, 1'b1, 1'b1, 4'd14, 5'd16);
        pressButton(0);
        checkOutput("unfreeze", 16'h0013, 8'h53, 1'b0, 1'b0, 1'b0, 4'd0, 5'd16);
        applyStimulus(16'hBEEF, 8'h5A, 1'b1, 1'b0);
        checkOutput("live_again", 16'hBEEF, 8'h5A, 1'b1, 1'b0, 1'b0, 4'd0, 5'd16);

        // Bouncing freeze button, then a steady press
        risesBefore = freezeRises;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            btn_freeze = ((k / 2) % 2) == 0;
        end
        @(negedge clk);
        btn_freeze = 1'b0;
        checkOutput("bounce", 16'hBEEF, 8'h5A, 1'b1, 1'b0, 1'b0, 4'd0, 5'd16);
        @(negedge clk);
        btn_freeze = 1'b1;
        repeat (6) @(negedge clk);
        checkOutput("steady", 16'hBEEF, 8'h5A, 1'b1, 1'b1, 1'b0, 4'd0, 5'd16);
        @(negedge clk);
        btn_freeze = 1'b0;
        repeat (10) @(negedge clk);
        #1;
        cmp("freeze_rises", 32'(freezeRises - risesBefore), 32'd1);
        @(negedge clk);
        btn_freeze = 1'b1;
        repeat (3) @(negedge clk);
        btn_freeze = 1'b0;
        repeat (10) @(negedge clk);
        checkOutput("short_pulse", 16'hBEEF, 8'h5A, 1'b1, 1'b1, 1'b0, 4'd0, 5'd16);

        // Browse to position 5, then reset asynchronously mid-cycle
        for (int i = 0; i < 5; i++)
            pressButton(1);
        checkOutput("pos5", 16'h000F, 8'h4F, 1'b0, 1'b1, 1'b0, 4'd5, 5'd16);
        @(posedge clk);
        #1;
        pushExpect("async_reset", 16'h0, 8'h0, 1'b0, 1'b0, 1'b0, 4'd0, 5'd0);
        #1;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        pressButton(1);
        pressButton(1);
        checkOutput("post_reset", 16'h0, 8'h0, 1'b0, 1'b0, 1'b0, 4'd0, 5'd0);

        repeat (3) @(negedge clk);
        #1;
        cmp("queue_drained", 32'(expQ.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        errors++;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1, "[TB] watchdog expired");
    end
endmodule
